// File: rtl/phys_reg_free_list_ctrl.sv
// Physical-register free list for the rename stage.
// A circular buffer of free tags is read at the speculative head and refilled at the tail.
// The committed head marks the oldest allocation that has not retired yet.
// On a flush the speculative head returns to the committed head.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | power-up fill: one tag is written per cycle, no allocation
// ST_RUN   | normal allocate / release / commit operation
// ST_RECOV | the cycle after a flush: allocation is held off
module phys_reg_free_list_ctrl #(
  parameter int PHYS_REG_NUM = 64,
  parameter int ARCH_REG_NUM = 32,
  parameter int REL_W        = 2,
  parameter int PREG_W       = $clog2(PHYS_REG_NUM)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alloc_req,
  output logic                    alloc_rdy,
  output logic [PREG_W-1:0]       alloc_preg,
  input  logic                    commit_alloc,
  input  logic [REL_W-1:0]        rel_en,
  input  logic [REL_W*PREG_W-1:0] rel_preg,
  input  logic                    flush,
  output logic [PREG_W:0]         free_count,
  output logic                    init_done,
  output logic                    err_overflow,
  output logic                    err_underflow
);

  localparam int PTR_W = PREG_W + 1;
  localparam int CNT_W = $clog2(REL_W + 1);
  localparam logic [PTR_W-1:0] FILL_LAST = PTR_W'(PHYS_REG_NUM - ARCH_REG_NUM - 1);
  localparam logic [PTR_W:0]   CAPACITY  = (PTR_W + 1)'(PHYS_REG_NUM);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_RECOV} state_t;

  state_t state, state_nxt;

  logic [PREG_W-1:0] mem [PHYS_REG_NUM];
  logic [PTR_W-1:0]  head, commit_head, tail;
  logic [PTR_W-1:0]  free_raw, occupancy;
  logic              commit_ok, grant, rel_ovf, rel_apply;

  logic [PREG_W-1:0] lane_tag [REL_W];
  logic [CNT_W-1:0]  lane_off [REL_W];
  logic [REL_W-1:0]  lane_ok;
  logic [CNT_W-1:0]  n_rel;

  // Pack the release lanes: tag 0 is dropped, survivors take consecutive slots from the tail.
  always_comb begin
    n_rel = '0;
    for (int i = 0; i < REL_W; i++) begin
      lane_tag[i] = rel_preg[i*PREG_W +: PREG_W];
      lane_ok[i]  = rel_en[i] && (lane_tag[i] != '0);
      lane_off[i] = n_rel;
      n_rel       = n_rel + CNT_W'(lane_ok[i]);
    end
  end

  // Occupancy, overflow, commit and grant qualification.
  always_comb begin
    free_raw  = tail - head;
    occupancy = tail - commit_head;
    commit_ok = commit_alloc && (head != commit_head);
    rel_ovf   = (n_rel != '0) &&
                (({1'b0, occupancy} + (PTR_W + 1)'(n_rel)) > CAPACITY);
    rel_apply = (state != ST_INIT) && !rel_ovf;
    grant     = alloc_req && alloc_rdy;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // Next-state logic; a flush during the fill is ignored.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT:  if (tail == FILL_LAST) state_nxt = ST_RUN;
      ST_RUN:   if (flush) state_nxt = ST_RECOV;
      ST_RECOV: state_nxt = flush ? ST_RECOV : ST_RUN;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // Outputs; everything reads as zero while the fill is in progress.
  always_comb begin
    alloc_rdy  = (state == ST_RUN) && (free_raw != '0) && !flush;
    init_done  = (state != ST_INIT);
    free_count = (state == ST_INIT) ? '0 : free_raw;
    alloc_preg = (state == ST_INIT) ? '0 : mem[head[PREG_W-1:0]];
  end

  // Pointers and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      head          <= '0;
      commit_head   <= '0;
      tail          <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (state == ST_INIT) begin
      tail <= tail + 1'b1;
      if (|rel_en)      err_overflow  <= 1'b1;
      if (commit_alloc) err_underflow <= 1'b1;
    end else begin
      if (commit_alloc && !commit_ok) err_underflow <= 1'b1;
      if (commit_ok) commit_head <= commit_head + 1'b1;
      if (flush)      head <= commit_head + PTR_W'(commit_ok);
      else if (grant) head <= head + 1'b1;
      if (rel_ovf) err_overflow <= 1'b1;
      else         tail <= tail + PTR_W'(n_rel);
    end
  end

  // Tag storage: fill writes during init, packed release writes afterwards; never cleared.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[tail[PREG_W-1:0]] <= PREG_W'(ARCH_REG_NUM) + tail[PREG_W-1:0];
    end else if (rel_apply) begin
      for (int i = 0; i < REL_W; i++) begin
        if (lane_ok[i]) mem[tail[PREG_W-1:0] + PREG_W'(lane_off[i])] <= lane_tag[i];
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list_ctrl.sv
// Bench for phys_reg_free_list_ctrl: directed vectors plus random traffic against a queue model.
module tb_phys_reg_free_list_ctrl;

  logic        clk = 1'b0;
  logic        reset, alloc_req, commit_alloc, flush;
  logic [1:0]  rel_en;
  logic [11:0] rel_preg;
  logic        alloc_rdy, init_done, err_overflow, err_underflow;
  logic [5:0]  alloc_preg;
  logic [6:0]  free_count;

  phys_reg_free_list_ctrl dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_rdy(alloc_rdy),
    .alloc_preg(alloc_preg), .commit_alloc(commit_alloc), .rel_en(rel_en),
    .rel_preg(rel_preg), .flush(flush), .free_count(free_count),
    .init_done(init_done), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: free tags in allocation order, and tags handed out but not yet committed.
  logic [5:0] spec_q[$];
  logic [5:0] outst_q[$];
  int  init_left = 0;
  bit  recov = 0, m_ovf = 0, m_unf = 0, known = 0;

  typedef struct {
    bit         req;
    logic [1:0] en;
    logic [5:0] t1, t0;
    bit         cm, fl;
    bit         e_rdy;
    int         e_preg;
    int         e_free;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit req, input logic [1:0] en, input logic [5:0] t1,
                       input logic [5:0] t0, input bit cm, input bit fl, input bit rs);
    alloc_req = req; rel_en = en; rel_preg = {t1, t0};
    commit_alloc = cm; flush = fl; reset = rs;
  endtask

  task automatic model_check();
    bit in_init;
    if (!known) return;
    in_init = (init_left > 0);
    chk("rdy", alloc_rdy, (!in_init && !recov && spec_q.size() != 0 && !flush) ? 1 : 0);
    chk("free_count", free_count, in_init ? 0 : spec_q.size());
    chk("init_done", init_done, in_init ? 0 : 1);
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_underflow", err_underflow, m_unf);
    if (!in_init && spec_q.size() != 0) chk("alloc_preg", alloc_preg, spec_q[0]);
  endtask

  task automatic model_update();
    bit grant, cval;
    int n, occ;
    logic [5:0] tags[2];
    if (reset) begin
      spec_q.delete(); outst_q.delete();
      init_left = 32; recov = 0; m_ovf = 0; m_unf = 0; known = 1;
      return;
    end
    if (!known) return;
    if (init_left > 0) begin
      if (rel_en != 2'b00) m_ovf = 1;
      if (commit_alloc) m_unf = 1;
      spec_q.push_back(6'(32 + (32 - init_left)));
      init_left--;
      return;
    end
    grant = alloc_req && !recov && spec_q.size() != 0 && !flush;
    cval  = commit_alloc && outst_q.size() != 0;
    if (commit_alloc && !cval) m_unf = 1;
    occ = outst_q.size() + spec_q.size();
    n = 0;
    for (int i = 0; i < 2; i++) begin
      if (rel_en[i] && rel_preg[i*6 +: 6] != 6'd0) begin
        tags[n] = rel_preg[i*6 +: 6];
        n++;
      end
    end
    if (cval) void'(outst_q.pop_front());
    if (grant) outst_q.push_back(spec_q.pop_front());
    if (n > 0 && occ + n > 64) m_ovf = 1;
    else for (int i = 0; i < n; i++) spec_q.push_back(tags[i]);
    if (flush) begin
      spec_q = {outst_q, spec_q};
      outst_q.delete();
      recov = 1;
    end else begin
      recov = 0;
    end
  endtask

  task automatic half_a();
    @(negedge clk);
    model_check();
  endtask

  task automatic half_b();
    model_update();
    @(posedge clk);
    #1;
    drive(0, 2'b00, 6'd0, 6'd0, 0, 0, 0);
  endtask

  task automatic cyc(input bit req, input logic [1:0] en, input logic [5:0] t1,
                     input logic [5:0] t0, input bit cm, input bit fl, input bit rs);
    drive(req, en, t1, t0, cm, fl, rs);
    half_a();
    half_b();
  endtask

  initial begin
    //           req en     t1    t0    cm fl  rdy preg free
    tbl[0] = '{1, 2'b00, 6'd0, 6'd0, 0, 0, 1, 32, 32};
    tbl[1] = '{1, 2'b00, 6'd0, 6'd0, 0, 0, 1, 33, 31};
    tbl[2] = '{1, 2'b00, 6'd0, 6'd0, 0, 0, 1, 34, 30};
    tbl[3] = '{1, 2'b00, 6'd0, 6'd0, 0, 0, 1, 35, 29};
    tbl[4] = '{1, 2'b00, 6'd0, 6'd0, 0, 0, 1, 36, 28};
    tbl[5] = '{0, 2'b00, 6'd0, 6'd0, 1, 0, 1, 37, 27};
    tbl[6] = '{0, 2'b00, 6'd0, 6'd0, 1, 0, 1, 37, 27};
    tbl[7] = '{1, 2'b00, 6'd0, 6'd0, 0, 1, 0, 37, 27};
    tbl[8] = '{0, 2'b00, 6'd0, 6'd0, 0, 0, 0, 34, 30};
    tbl[9] = '{0, 2'b00, 6'd0, 6'd0, 0, 0, 1, 34, 30};

    drive(0, 2'b00, 6'd0, 6'd0, 0, 0, 1);
    @(posedge clk); #1;
    cyc(0, 2'b00, 6'd0, 6'd0, 0, 0, 1);

    // Power-up fill
    for (int i = 0; i < 31; i++) cyc(0, 2'b00, 6'd0, 6'd0, 0, 0, 0);
    chk("t1_init_done_early", init_done, 0);
    cyc(0, 2'b00, 6'd0, 6'd0, 0, 0, 0);
    chk("t1_init_done", init_done, 1);
    chk("t1_free_after_fill", free_count, 32);

    // Grants, commits, flush and recovery
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].req, tbl[i].en, tbl[i].t1, tbl[i].t0, tbl[i].cm, tbl[i].fl, 0);
      half_a();
      chk($sformatf("vec%0d_rdy", i), alloc_rdy, tbl[i].e_rdy);
      chk($sformatf("vec%0d_preg", i), alloc_preg, tbl[i].e_preg);
      chk($sformatf("vec%0d_free", i), free_count, tbl[i].e_free);
      half_b();
    end

    // Drain every free tag, then one release refills the head
    for (int i = 0; i < 30; i++) cyc(1, 2'b00, 6'd0, 6'd0, 0, 0, 0);
    chk("t2_free_empty", free_count, 0);
    drive(1, 2'b00, 6'd0, 6'd0, 0, 0, 0);
    half_a();
    chk("t2_rdy_empty", alloc_rdy, 0);
    half_b();
    cyc(0, 2'b01, 6'd0, 6'd40, 0, 0, 0);
    chk("t2_preg_after_rel", alloc_preg, 40);
    chk("t2_rdy_after_rel", alloc_rdy, 1);

    // Dual-lane release together with a grant
    drive(1, 2'b11, 6'd7, 6'd9, 0, 0, 0);
    half_a();
    chk("t4_grant_preg", alloc_preg, 40);
    half_b();
    chk("t4_free_net", free_count, 2);
    chk("t4_lane0_first", alloc_preg, 9);
    cyc(1, 2'b00, 6'd0, 6'd0, 0, 0, 0);
    chk("t4_lane1_second", alloc_preg, 7);

    // Retire everything, fill the ring completely, then overflow and underflow
    for (int i = 0; i < 32; i++) cyc(0, 2'b00, 6'd0, 6'd0, 1, 0, 0);
    chk("t5_free_one", free_count, 1);
    for (int i = 0; i < 31; i++) cyc(0, 2'b11, 6'(2*i + 2), 6'(2*i + 1), 0, 0, 0);
    cyc(0, 2'b01, 6'd0, 6'd63, 0, 0, 0);
    chk("t5_free_full", free_count, 64);
    cyc(0, 2'b01, 6'd0, 6'd0, 0, 0, 0);
    chk("t5_tag0_no_ovf", err_overflow, 0);
    cyc(0, 2'b01, 6'd0, 6'd5, 0, 0, 0);
    chk("t5_ovf_set", err_overflow, 1);
    chk("t5_ovf_free_same", free_count, 64);
    cyc(0, 2'b00, 6'd0, 6'd0, 1, 0, 0);
    chk("t5_unf_set", err_underflow, 1);

    // Reset while recovering from a flush
    for (int i = 0; i < 10; i++) cyc(1, 2'b00, 6'd0, 6'd0, 0, 0, 0);
    cyc(0, 2'b00, 6'd0, 6'd0, 0, 1, 0);
    cyc(0, 2'b00, 6'd0, 6'd0, 0, 0, 1);
    chk("t6_ovf_cleared", err_overflow, 0);
    chk("t6_unf_cleared", err_underflow, 0);
    chk("t6_init_done_low", init_done, 0);
    for (int i = 0; i < 32; i++) cyc(0, 2'b00, 6'd0, 6'd0, 0, 0, 0);
    chk("t6_refill_free", free_count, 32);
    chk("t6_refill_preg", alloc_preg, 32);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] en;
      en[0] = ($urandom_range(0, 5) == 0);
      en[1] = ($urandom_range(0, 5) == 0);
      cyc($urandom_range(0, 3) != 0, en, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
          $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1499) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
